// File: rtl/key_expansion_pkg.sv
// rtl/key_expansion_pkg.sv - shared types, constants and helpers for AES-128 key expansion
package key_expansion_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EMIT   = 2'd1,
        ST_FINISH = 2'd2
    } ke_state_e;

    localparam int unsigned AES_ROUNDS = 10;
    localparam logic [7:0]  RCON_INIT  = 8'h01;
    localparam logic [7:0]  XTIME_POLY = 8'h1b;

    // GF(2^8) multiply-by-two used to advance the round constant
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/key_expansion_if.sv
// rtl/key_expansion_if.sv - control and round-key handshake bundle of the key expander
interface key_expansion_if;
    logic         start;
    logic [127:0] key;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] round_key;
    logic [3:0]   rk_index;
    logic         busy;
    logic         done;

    modport master (
        input  start,
        input  key,
        input  rk_ready,
        output rk_valid,
        output round_key,
        output rk_index,
        output busy,
        output done
    );

    modport slave (
        output start,
        output key,
        output rk_ready,
        input  rk_valid,
        input  round_key,
        input  rk_index,
        input  busy,
        input  done
    );
endinterface

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational FIPS-197 forward S-box, one byte in, one byte out
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    // Row-major table; entry 0x00 sits in the most significant byte
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] bit_hi;

    always_comb begin
        bit_hi = 11'd2047 - {in_i, 3'b000};
        out_o  = SBOX_TABLE[bit_hi -: 8];
    end

endmodule

// File: rtl/key_expansion.sv
// rtl/key_expansion.sv - AES-128 key schedule streaming one round key per accepted handshake
module key_expansion
    import key_expansion_pkg::*;
#(
    parameter int unsigned ROUNDS = AES_ROUNDS
) (
    input  logic              clk,
    input  logic              rst_n,
    key_expansion_if.master   bus
);

    localparam logic [3:0] LAST_IDX = 4'(ROUNDS);

    ke_state_e    state_q, state_d;
    logic [127:0] round_key_q, round_key_d;
    logic [3:0]   rk_index_q, rk_index_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         rk_valid_q, rk_valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w3, sub_w3, t_word;
    logic [31:0]  nw0, nw1, nw2, nw3;
    logic         handshake;

    assign w0 = round_key_q[127:96];
    assign w1 = round_key_q[95:64];
    assign w2 = round_key_q[63:32];
    assign w3 = round_key_q[31:0];

    assign rot_w3 = rot_word(w3);

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .in_i  (rot_w3[8*g +: 8]),
            .out_o (sub_w3[8*g +: 8])
        );
    end

    assign t_word = sub_w3 ^ {rcon_q, 24'h000000};
    assign nw0    = w0 ^ t_word;
    assign nw1    = w1 ^ nw0;
    assign nw2    = w2 ^ nw1;
    assign nw3    = w3 ^ nw2;

    assign handshake = rk_valid_q & bus.rk_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            round_key_q <= '0;
            rk_index_q  <= '0;
            rcon_q      <= RCON_INIT;
            rk_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_key_q <= round_key_d;
            rk_index_q  <= rk_index_d;
            rcon_q      <= rcon_d;
            rk_valid_q  <= rk_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        round_key_d = round_key_q;
        rk_index_d  = rk_index_q;
        rcon_d      = rcon_q;
        rk_valid_d  = rk_valid_q;
        busy_d      = busy_q;
        done_d      = done_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    round_key_d = bus.key;
                    rk_index_d  = '0;
                    rcon_d      = RCON_INIT;
                    rk_valid_d  = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_EMIT;
                end
            end
            ST_EMIT: begin
                // Without a completed handshake every output holds its value
                if (handshake) begin
                    if (rk_index_q == LAST_IDX) begin
                        rk_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = ST_FINISH;
                    end else begin
                        round_key_d = {nw0, nw1, nw2, nw3};
                        rk_index_d  = rk_index_q + 4'd1;
                        rcon_d      = xtime(rcon_q);
                    end
                end
            end
            ST_FINISH: begin
                done_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.rk_valid  = rk_valid_q;
    assign bus.round_key = round_key_q;
    assign bus.rk_index  = rk_index_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_key_expansion.sv
// tb/tb_key_expansion.sv - scoreboard bench for key_expansion with FIPS-197 directed vectors
module tb_key_expansion;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
        bit           chk_key;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    int   stall_cnt;
    int   done_cnt;
    exp_t exp_q[$];

    logic [127:0] fips_k [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    logic [127:0] ones_k0 = {128{1'b1}};
    logic [127:0] ones_k1 = 128'he8e9e9e917161616e8e9e9e917161616;

    key_expansion_if bus ();

    key_expansion dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fips();
        exp_t e;
        for (int i = 0; i <= 10; i++) begin
            e.idx = 4'(i);
            e.key = fips_k[i];
            e.chk_key = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_ones();
        exp_t e;
        for (int i = 0; i <= 10; i++) begin
            e.idx = 4'(i);
            e.key = (i == 0) ? ones_k0 : ones_k1;
            e.chk_key = (i < 2);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_start(input logic [127:0] k, output int c0);
        bus.key   = k;
        bus.start = 1'b1;
        c0 = cyc;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int c1);
        bit seen;
        seen = 1'b0;
        c1 = cyc;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                c1 = cyc;
            end else begin
                step();
            end
        end
        chk({name, "_done_seen"}, 128'(seen), 128'd1);
    endtask

    task automatic wait_index(input string name, input logic [3:0] idx);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.rk_valid && bus.rk_index == idx) seen = 1'b1;
            else step();
        end
        chk({name, "_index_seen"}, 128'(seen), 128'd1);
    endtask

    // Monitor: pops the scoreboard on every handshake and polices stalls and done
    bit           prev_stall;
    bit           prev_done;
    logic [127:0] prev_key;
    logic [3:0]   prev_idx;
    exp_t         got;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 128'(bus.rk_valid), 128'd1);
                chk("stall_index", 128'(bus.rk_index), 128'(prev_idx));
                chk("stall_key", bus.round_key, prev_key);
            end
            if (bus.rk_valid && !bus.rk_ready) begin
                stall_cnt++;
                prev_stall = 1'b1;
                prev_key   = bus.round_key;
                prev_idx   = bus.rk_index;
            end else begin
                prev_stall = 1'b0;
            end
            if (bus.rk_valid && bus.rk_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_key actual_index=%0d required=none", bus.rk_index);
                end else begin
                    got = exp_q.pop_front();
                    chk("rk_index", 128'(bus.rk_index), 128'(got.idx));
                    if (got.chk_key) chk("round_key", bus.round_key, got.key);
                end
            end
            if (bus.done) begin
                done_cnt++;
                chk("done_width", 128'(prev_done), 128'd0);
                chk("done_busy", 128'(bus.busy), 128'd0);
            end
            prev_done = bus.done;
        end
    end

    int c0, c1, c2, s0, d0;

    initial begin
        cyc = 0; checks = 0; errors = 0; stall_cnt = 0; done_cnt = 0;
        bus.start = 1'b0;
        bus.key = '0;
        bus.rk_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_valid", 128'(bus.rk_valid), 128'd0);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_done", 128'(bus.done), 128'd0);
        chk("rst_index", 128'(bus.rk_index), 128'd0);
        chk("rst_key", bus.round_key, 128'd0);
        rst_n = 1'b1;
        step();

        // FIPS-197 vector, ready always high
        push_fips();
        run_start(fips_k[0], c0);
        chk("fips_busy", 128'(bus.busy), 128'd1);
        wait_done("fips", c1);
        chk("fips_latency", 128'(c1 - c0), 128'd12);
        step();
        chk("fips_drained", 128'(exp_q.size()), 128'd0);
        chk("idle_valid", 128'(bus.rk_valid), 128'd0);
        chk("idle_key_kept", bus.round_key, fips_k[10]);

        // All-ones key
        push_ones();
        run_start(ones_k0, c0);
        wait_done("ones", c1);
        step();
        chk("ones_drained", 128'(exp_q.size()), 128'd0);

        // Back-pressure for five cycles at index 3
        push_fips();
        run_start(fips_k[0], c0);
        wait_index("stall", 4'd3);
        s0 = stall_cnt;
        bus.rk_ready = 1'b0;
        repeat (5) step();
        bus.rk_ready = 1'b1;
        wait_done("stall", c1);
        chk("stall_cycles", 128'(stall_cnt - s0), 128'd5);
        step();
        chk("stall_drained", 128'(exp_q.size()), 128'd0);

        // A second start mid-expansion must not disturb the sequence
        push_fips();
        run_start(fips_k[0], c0);
        wait_index("restart", 4'd5);
        run_start(ones_k0, c2);
        bus.key = fips_k[0];
        wait_done("restart", c1);
        step();
        chk("restart_drained", 128'(exp_q.size()), 128'd0);

        // Asynchronous reset at index 6, then a clean run
        push_fips();
        run_start(fips_k[0], c0);
        wait_index("abort", 4'd6);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_valid", 128'(bus.rk_valid), 128'd0);
        chk("abort_busy", 128'(bus.busy), 128'd0);
        chk("abort_done", 128'(bus.done), 128'd0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("post_rst_valid", 128'(bus.rk_valid), 128'd0);
        chk("post_rst_index", 128'(bus.rk_index), 128'd0);
        chk("post_rst_key", bus.round_key, 128'd0);
        push_fips();
        run_start(fips_k[0], c0);
        wait_done("after_rst", c1);
        chk("after_rst_latency", 128'(c1 - c0), 128'd12);
        step();
        chk("after_rst_drained", 128'(exp_q.size()), 128'd0);

        // Start held high: two expansions back to back
        push_fips();
        push_fips();
        d0 = done_cnt;
        bus.key = fips_k[0];
        bus.start = 1'b1;
        step();
        wait_done("held1", c1);
        step();
        wait_done("held2", c2);
        bus.start = 1'b0;
        chk("held_spacing", 128'(c2 - c1), 128'd13);
        repeat (3) step();
        chk("held_done_count", 128'(done_cnt - d0), 128'd2);
        chk("held_drained", 128'(exp_q.size()), 128'd0);
        chk("held_idle_valid", 128'(bus.rk_valid), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
